// File: rtl/up_timer.sv
// -----------------------------------------------------------------------------
// up_timer
//
// Minutes:seconds up-counter in packed BCD (00:00 .. 99:59) with a
// start/stop/clear control FSM, an optional target compare that parks the
// counter in DONE, and a one-cycle overflow pulse on the 99:59 -> 00:00 wrap.
//
// Parameters
//   TGT_EN   : 1 = target compare active, 0 = free-running (done stays 0)
//
// Ports
//   clk      : in  1   system clock, all state on rising edge
//   reset    : in  1   asynchronous active-high reset
//   tick     : in  1   count enable, one-cycle pulse per second
//   start    : in  1   level: begin/resume counting
//   stop     : in  1   level: pause counting
//   clear    : in  1   level: return to 00:00 and IDLE
//   target   : in  16  BCD target {min_tens, min_ones, sec_tens, sec_ones}
//   value    : out 16  registered BCD count, same digit order as target
//   state    : out 2   IDLE=00, RUN=01, PAUSE=10, DONE=11
//   done     : out 1   high while state is DONE
//   overflow : out 1   one-cycle pulse in the cycle after the wrap
// -----------------------------------------------------------------------------
module up_timer #(
  parameter int TGT_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic [15:0] target,
  output logic [15:0] value,
  output logic [1:0]  state,
  output logic        done,
  output logic        overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // One-second BCD increment with ripple carry; 99:59 rolls over to 00:00.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [3:0] s_one;
    logic [3:0] s_ten;
    logic [3:0] m_one;
    logic [3:0] m_ten;
    s_one = v[3:0];
    s_ten = v[7:4];
    m_one = v[11:8];
    m_ten = v[15:12];
    if (s_one != 4'd9) begin
      s_one = s_one + 4'd1;
    end else begin
      s_one = 4'd0;
      if (s_ten != 4'd5) begin
        s_ten = s_ten + 4'd1;
      end else begin
        s_ten = 4'd0;
        if (m_one != 4'd9) begin
          m_one = m_one + 4'd1;
        end else begin
          m_one = 4'd0;
          if (m_ten != 4'd9) begin
            m_ten = m_ten + 4'd1;
          end else begin
            m_ten = 4'd0;
          end
        end
      end
    end
    return {m_ten, m_one, s_ten, s_one};
  endfunction

  // A target is usable only if it is non-zero and every digit is in range.
  // An unusable target can never match, so the timer simply keeps counting.
  function automatic logic tgt_valid(input logic [15:0] t);
    logic ok;
    ok = (t != 16'h0000);
    if (t[3:0]   > 4'd9) ok = 1'b0;
    if (t[7:4]   > 4'd5) ok = 1'b0;
    if (t[11:8]  > 4'd9) ok = 1'b0;
    if (t[15:12] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers and next-state wires
  // ---------------------------------------------------------------------------
  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_value;
  logic [15:0] w_value_nxt;
  logic        r_overflow;
  logic        w_overflow_nxt;

  logic [15:0] w_inc;
  logic        w_wrap;
  logic        w_match;

  assign w_inc   = bcd_inc(r_value);
  assign w_wrap  = (r_value == 16'h9959);
  // Compare the value about to be loaded, so DONE and the final value land
  // on the same edge. Target is sampled live: a lowered target never causes
  // a retroactive DONE because only exact equality on an increment counts.
  assign w_match = (TGT_EN != 0) && tgt_valid(target) && (w_inc == target);

  // ---------------------------------------------------------------------------
  // State / data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_value    <= 16'h0000;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_value    <= w_value_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-data logic; priority clear > stop > start > tick
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_value_nxt    = r_value;
    w_overflow_nxt = 1'b0;

    if (clear) begin
      w_state_nxt = S_IDLE;
      w_value_nxt = 16'h0000;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // Entry cycle into RUN never counts, even with tick high.
          if (!stop && start) begin
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            // Pause takes precedence over a coincident tick.
            w_state_nxt = S_PAUSE;
          end else if (tick) begin
            w_value_nxt    = w_inc;
            w_overflow_nxt = w_wrap;
            if (w_match) begin
              w_state_nxt = S_DONE;
            end
          end
        end
        S_PAUSE: begin
          if (!stop && start) begin
            w_state_nxt = S_RUN;
          end
        end
        S_DONE: begin
          // Held until clear; start/stop/tick have no effect.
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_value_nxt = 16'h0000;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign value    = r_value;
  assign state    = r_state;
  assign done     = (TGT_EN != 0) && (r_state == S_DONE);
  assign overflow = r_overflow;

endmodule

// File: tb/tb_up_timer.sv
module tb_up_timer;

  logic        clk;
  logic        reset;
  logic        tick;
  logic        start;
  logic        stop;
  logic        clear;
  logic [15:0] target;
  logic [15:0] value;
  logic [1:0]  state;
  logic        done;
  logic        overflow;

  logic [15:0] value_f;
  logic [1:0]  state_f;
  logic        done_f;
  logic        overflow_f;

  int checks = 0;
  int errors = 0;

  up_timer #(.TGT_EN(1)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .target(target), .value(value), .state(state),
    .done(done), .overflow(overflow)
  );

  // Free-running variant shares all inputs; it must never report DONE.
  up_timer #(.TGT_EN(0)) dut_free (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .target(target), .value(value_f), .state(state_f),
    .done(done_f), .overflow(overflow_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        sp;
    logic        cl;
    logic        tk;
    logic [15:0] tgt;
    logic [15:0] ev;
    logic [1:0]  es;
    logic        ed;
    logic        eo;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive controls, let one rising edge pass, then sample 1 time unit later.
  task automatic step(input logic st, input logic sp, input logic cl, input logic tk);
    start = st;
    stop  = sp;
    clear = cl;
    tick  = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [15:0] ev, input logic [1:0] es,
                         input logic ed, input logic eo);
    chk({nm, "_value"}, value, ev);
    chk({nm, "_state"}, {14'd0, state}, {14'd0, es});
    chk({nm, "_done"}, {15'd0, done}, {15'd0, ed});
    chk({nm, "_overflow"}, {15'd0, overflow}, {15'd0, eo});
  endtask

  initial begin
    int ovf_cnt;
    int done_cnt;

    // st sp cl tk  target    value     state  done ovf
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b1, 16'h0003, 16'h0000, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b0,1'b0, 16'h0003, 16'h0000, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b1, 16'h0003, 16'h0000, 2'd1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b1, 16'h0003, 16'h0001, 2'd1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b0, 16'h0003, 16'h0001, 2'd1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b1, 16'h0003, 16'h0002, 2'd1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b1, 16'h0003, 16'h0003, 2'd3, 1'b1, 1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b1, 16'h0003, 16'h0003, 2'd3, 1'b1, 1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b1, 16'h0003, 16'h0003, 2'd3, 1'b1, 1'b0};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b0, 16'h0003, 16'h0003, 2'd3, 1'b1, 1'b0};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b1, 16'h0003, 16'h0003, 2'd3, 1'b1, 1'b0};
    vecs[11] = '{1'b0,1'b0,1'b1,1'b0, 16'h0003, 16'h0000, 2'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b0, 16'h0000, 16'h0000, 2'd1, 1'b0, 1'b0};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b1, 16'h0000, 16'h0001, 2'd1, 1'b0, 1'b0};
    vecs[14] = '{1'b1,1'b1,1'b0,1'b1, 16'h0000, 16'h0001, 2'd2, 1'b0, 1'b0};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b1, 16'h0000, 16'h0001, 2'd2, 1'b0, 1'b0};
    vecs[16] = '{1'b1,1'b0,1'b0,1'b1, 16'h0000, 16'h0001, 2'd1, 1'b0, 1'b0};
    vecs[17] = '{1'b0,1'b0,1'b0,1'b1, 16'h0000, 16'h0002, 2'd1, 1'b0, 1'b0};
    vecs[18] = '{1'b1,1'b1,1'b1,1'b1, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0};
    vecs[19] = '{1'b1,1'b0,1'b0,1'b0, 16'h0002, 16'h0000, 2'd1, 1'b0, 1'b0};
    vecs[20] = '{1'b0,1'b0,1'b0,1'b1, 16'h0002, 16'h0001, 2'd1, 1'b0, 1'b0};
    vecs[21] = '{1'b0,1'b0,1'b0,1'b1, 16'h0001, 16'h0002, 2'd1, 1'b0, 1'b0};
    vecs[22] = '{1'b0,1'b0,1'b0,1'b1, 16'h0003, 16'h0003, 2'd3, 1'b1, 1'b0};
    vecs[23] = '{1'b0,1'b0,1'b1,1'b0, 16'h0003, 16'h0000, 2'd0, 1'b0, 1'b0};
    vecs[24] = '{1'b1,1'b0,1'b0,1'b0, 16'h0000, 16'h0000, 2'd1, 1'b0, 1'b0};
    vecs[25] = '{1'b0,1'b1,1'b0,1'b0, 16'h0000, 16'h0000, 2'd2, 1'b0, 1'b0};
    vecs[26] = '{1'b0,1'b0,1'b1,1'b0, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0};

    reset  = 1'b1;
    tick   = 1'b1;
    start  = 1'b1;
    stop   = 1'b0;
    clear  = 1'b0;
    target = 16'h0000;

    // Reset state, with start/tick asserted to show they are not acted on.
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 16'h0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    start = 1'b0;
    tick  = 1'b0;

    // Table-driven control sequence.
    for (int i = 0; i < NVEC; i++) begin
      target = vecs[i].tgt;
      step(vecs[i].st, vecs[i].sp, vecs[i].cl, vecs[i].tk);
      chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].es, vecs[i].ed, vecs[i].eo);
      chk($sformatf("vec%0d_free_done", i), {15'd0, done_f}, 16'h0000);
    end

    // 75 ticks from a fresh start -> 01:15.
    target = 16'h0000;
    step(1, 0, 0, 0);
    ovf_cnt = 0;
    for (int i = 0; i < 75; i++) begin
      step(0, 0, 0, 1);
      if (overflow) ovf_cnt++;
    end
    chk_all("t75", 16'h0115, 2'd1, 1'b0, 1'b0);
    chk("t75_ovf_cnt", ovf_cnt[15:0], 16'd0);

    // Stop wins over a coincident tick at 00:59; resume cycle does not count.
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    repeat (59) step(0, 0, 0, 1);
    chk("s59_value", value, 16'h0059);
    step(0, 1, 0, 1);
    chk_all("stop_tick", 16'h0059, 2'd2, 1'b0, 1'b0);
    step(1, 0, 0, 1);
    chk_all("resume_tick", 16'h0059, 2'd1, 1'b0, 1'b0);
    step(0, 0, 0, 1);
    chk_all("carry_min", 16'h0100, 2'd1, 1'b0, 1'b0);

    // 99:59 wrap with compare off.
    target = 16'h0000;
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    ovf_cnt = 0;
    for (int i = 0; i < 5999; i++) begin
      step(0, 0, 0, 1);
      if (overflow) ovf_cnt++;
    end
    chk("pre_wrap_value", value, 16'h9959);
    chk("pre_wrap_ovf_cnt", ovf_cnt[15:0], 16'd0);
    step(0, 0, 0, 1);
    chk_all("wrap", 16'h0000, 2'd1, 1'b0, 1'b1);
    chk("wrap_free_ovf", {15'd0, overflow_f}, 16'h0001);
    step(0, 0, 0, 0);
    chk_all("post_wrap", 16'h0000, 2'd1, 1'b0, 1'b0);

    // Invalid target digit: compare disabled over 700 ticks -> 11:40.
    target = 16'h0A00;
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    done_cnt = 0;
    for (int i = 0; i < 700; i++) begin
      step(0, 0, 0, 1);
      if (done || state == 2'd3) done_cnt++;
    end
    chk("bad_tgt_done_cnt", done_cnt[15:0], 16'd0);
    chk_all("bad_tgt", 16'h1140, 2'd1, 1'b0, 1'b0);

    // Invalid sec_tens digit in target (00:60) never matches on the way past.
    target = 16'h0060;
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    repeat (61) step(0, 0, 0, 1);
    chk_all("bad_sec_tens", 16'h0101, 2'd1, 1'b0, 1'b0);

    // Asynchronous reset mid-count at 00:42.
    target = 16'h0000;
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    repeat (42) step(0, 0, 0, 1);
    chk("pre_areset_value", value, 16'h0042);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_all("areset_async", 16'h0000, 2'd0, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk_all("areset_held", 16'h0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (3) step(0, 0, 0, 1);
    chk_all("post_areset_idle", 16'h0000, 2'd0, 1'b0, 1'b0);
    step(1, 0, 0, 1);
    chk_all("post_areset_start", 16'h0000, 2'd1, 1'b0, 1'b0);
    step(0, 0, 0, 1);
    chk("post_areset_tick", value, 16'h0001);

    // Asynchronous reset while DONE drops done immediately.
    target = 16'h0002;
    step(0, 0, 0, 1);
    chk_all("done_again", 16'h0002, 2'd3, 1'b1, 1'b0);
    chk("done_again_free_state", value_f, 16'h0002);
    chk("done_again_free_done", {15'd0, done_f}, 16'h0000);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_all("areset_done", 16'h0000, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/up_timer.md
UP_TIMER -- requirements
Module: up_timer

Interface
REQ-001 SHALL have parameter TGT_EN, default 1, meaning target compare enabled (0 = free-running, done never asserts).
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port tick  input  1  count enable, one-cycle pulse per second.
REQ-006 SHALL have port start  input  1  level, sampled each clk: begin/resume counting.
REQ-007 SHALL have port stop  input  1  level, sampled each clk: pause counting.
REQ-008 SHALL have port clear  input  1  level, sampled each clk: return to 00:00, IDLE.
REQ-009 SHALL have port target  input  16  BCD target {min_tens, min_ones, sec_tens, sec_ones}.
REQ-010 SHALL have port value  output  16  BCD count, same digit order as target, registered.
REQ-011 SHALL have port state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-012 SHALL have port done  output  1  high while state is DONE.
REQ-013 SHALL have port overflow  output  1  one-cycle pulse on 99:59 -> 00:00 wrap.

Function
REQ-014 SHALL count in BCD: sec_ones 0-9, sec_tens 0-5, min_ones 0-9, min_tens 0-9; each digit wraps to 0 and carries into the next on the increment.
REQ-015 SHALL increment value by one second on the clk edge where tick=1 and state is RUN with no higher-priority control; value updates one cycle after tick is sampled.
REQ-016 SHALL apply control priority clear > stop > start > tick within a cycle.
REQ-017 IDLE: value held at 0000; start -> RUN; tick ignored; stop ignored.
REQ-018 RUN: tick increments; stop -> PAUSE with no increment that cycle; clear -> IDLE with value 0000.
REQ-019 PAUSE: value held; start -> RUN; tick ignored; clear -> IDLE.
REQ-020 DONE: value held; start, stop and tick ignored; clear -> IDLE.
REQ-021 The IDLE->RUN or PAUSE->RUN transition cycle SHALL NOT increment even if tick=1; counting starts on the first tick after entry.
REQ-022 With TGT_EN=1, when the incremented value equals target, the same edge SHALL load the value and enter DONE; done rises with it.
REQ-023 Compare SHALL be disabled (never match) when target=0000 or target contains an invalid digit (any digit >9, or sec_tens >5).
REQ-024 Target changes SHALL take effect on the next compare only; the block SHALL NOT retroactively enter DONE if value already exceeds target.
REQ-025 On tick at 9959 in RUN, value SHALL become 0000, overflow SHALL pulse for exactly one cycle, and the state SHALL remain RUN (unless a valid target matched).
REQ-026 overflow SHALL be registered and SHALL be 0 in every cycle except the one following the wrap.
REQ-027 With TGT_EN=0, the FSM SHALL never enter DONE; done is constant 0.

Reset
REQ-028 reset=1 SHALL immediately, asynchronously, force value=0000, state=IDLE, done=0, overflow=0.
REQ-029 Reset asserted mid-count SHALL discard the count; after release the block SHALL wait in IDLE for start.
REQ-030 No control or tick SHALL be acted on during a cycle in which reset is high.

Verification
REQ-031 Scenario: reset, start, 75 ticks -> value=0115, state=RUN, overflow=0.
REQ-032 Scenario: target=0003, start, 3 ticks -> value=0003, state=DONE, done=1; 2 further ticks and start -> value stays 0003; clear -> 0000, IDLE.
REQ-033 Scenario: value=0059, stop and tick asserted in the same cycle -> value stays 0059, state=PAUSE; start with tick -> no increment; next tick -> 0100.
REQ-034 Scenario: target=0000 (compare off), value preset to 9959 by ticking, tick -> value=0000, overflow high exactly one cycle, state=RUN.
REQ-035 Scenario: target=0A00 (invalid digit), run 700 ticks -> never DONE, value=1140.
REQ-036 Scenario: reset pulsed asynchronously between clk edges at value=0042 in RUN -> outputs zero before the next edge, state=IDLE, tick ignored until start.
